// File: rtl/s_pl_pipe.sv
// Elastic multi-stage pipeline register with valid/ready handshake on both sides.
// Bubbles collapse under back-pressure; synchronous flush and a registered occupancy count.
module s_pl_pipe #(
    parameter int              SIZE    = 8,
    parameter int              DEPTH   = 2,
    parameter int              CNT_W   = 2,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ivld,
    output logic             irdy,
    input  logic [SIZE-1:0]  idat,
    output logic             ovld,
    input  logic             ordy,
    output logic [SIZE-1:0]  odat,
    output logic [CNT_W-1:0] occ
);

    logic [DEPTH-1:0] vld;
    logic [SIZE-1:0]  dat [DEPTH];

    logic [DEPTH:0]   rdy;
    logic [DEPTH:0]   src_v;
    logic [SIZE-1:0]  src_d [DEPTH+1];
    logic [DEPTH-1:0] vld_nxt;
    logic [CNT_W-1:0] occ_nxt;

    // Ready ripples from the output back to the input; a stage can take a
    // beat if it is empty or everything in front of it can move.
    always_comb begin
        logic acc;
        acc        = ordy;
        rdy        = '0;
        rdy[DEPTH] = ordy;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc    = !vld[k] | acc;
            rdy[k] = acc;
        end
    end

    // Source of each stage: the upstream port for stage 0, the previous stage otherwise.
    always_comb begin
        src_v[0] = ivld;
        src_d[0] = idat;
        for (int k = 0; k < DEPTH; k++) begin
            src_v[k+1] = vld[k];
            src_d[k+1] = dat[k];
        end
    end

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        vld_nxt = vld;
        occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (rdy[k]) begin
                vld_nxt[k] = src_v[k];
            end
        end
        if (flush) begin
            vld_nxt = '0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            occ_nxt = occ_nxt + CNT_W'(vld_nxt[k]);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every stage
    // samples its neighbour's pre-edge value.
    // NOTE: the data registers are deliberately reset so odat shows RST_VAL after reset;
    // flush clears only the valids and leaves data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            occ <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat[k] <= RST_VAL;
            end
        end else begin
            vld <= vld_nxt;
            occ <= occ_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                if (!flush && rdy[k] && src_v[k]) begin
                    dat[k] <= src_d[k];
                end
            end
        end
    end

    assign irdy = rdy[0] & !flush;
    assign ovld = vld[DEPTH-1];
    assign odat = dat[DEPTH-1];

    // Structural invariants: occupancy tracks the valid bits and a stalled output is held.
    a_occ_bound : assert property (@(posedge clk) rst_n |-> (occ <= CNT_W'(DEPTH)));
    a_occ_count : assert property (@(posedge clk) occ == CNT_W'($countones(vld)));
    a_stall_hold : assert property (@(posedge clk)
        (rst_n && !flush && ovld && !ordy) |=> (ovld && $stable(odat)));

endmodule

// File: tb/tb_s_pl_pipe.sv
// Scoreboard bench for s_pl_pipe (DEPTH=3, SIZE=8, RST_VAL=8'hA5).
// Accepted beats are queued at the input handshake and compared at the output handshake.
module tb_s_pl_pipe;

    localparam int              SIZE    = 8;
    localparam int              DEPTH   = 3;
    localparam int              CNT_W   = 2;
    localparam logic [SIZE-1:0] RST_VAL = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             ivld;
    logic             irdy;
    logic [SIZE-1:0]  idat;
    logic             ovld;
    logic             ordy;
    logic [SIZE-1:0]  odat;
    logic [CNT_W-1:0] occ;

    logic [SIZE-1:0] sb [$];
    int n_vec = 0;
    int n_err = 0;

    s_pl_pipe #(
        .SIZE   (SIZE),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .RST_VAL(RST_VAL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .ivld (ivld),
        .irdy (irdy),
        .idat (idat),
        .ovld (ovld),
        .ordy (ordy),
        .odat (odat),
        .occ  (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: evaluate handshakes away from the edge, update the scoreboard,
    // advance one edge, then compare the occupancy with the scoreboard depth.
    task automatic tick();
        logic was_flush;
        logic was_rst;
        #1;
        was_flush = flush;
        was_rst   = !rst_n;
        if (rst_n) begin
            check("irdy", {31'b0, irdy},
                  {31'b0, !flush && ((sb.size() < DEPTH) || ordy)});
            if (ovld && ordy) begin
                if (sb.size() == 0)
                    check("spurious_out", {24'b0, odat}, 32'hFFFF_FFFF);
                else
                    check("odat", {24'b0, odat}, {24'b0, sb.pop_front()});
            end
            if (ivld && irdy) sb.push_back(idat);
        end
        @(posedge clk);
        #1;
        if (was_flush || was_rst) sb.delete();
        check("occ", {30'b0, occ}, sb.size());
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ivld  = 1'b0;
        idat  = '0;
        ordy  = 1'b0;

        // Reset / idle
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_ovld", {31'b0, ovld}, 0);
        check("rst_odat", {24'b0, odat}, {24'b0, RST_VAL});
        check("rst_occ", {30'b0, occ}, 0);
        check("rst_irdy", {31'b0, irdy}, 1);

        // Streaming: 8 beats back to back, first output three cycles after first input
        ordy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            ivld = (c < 8);
            idat = 8'(c + 1);
            check("lat_ovld", {31'b0, ovld}, {31'b0, (c >= 3) && (c < 11)});
            tick();
        end
        ivld = 1'b0;
        check("stream_empty", {31'b0, ovld}, 0);

        // Back-pressure fill, then drain
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ivld = 1'b1;
            idat = 8'(8'h10 + i);
            tick();
        end
        check("full_occ", {30'b0, occ}, 3);
        ivld = 1'b1;
        idat = 8'h99;
        #1;
        check("full_irdy", {31'b0, irdy}, 0);
        check("full_ovld", {31'b0, ovld}, 1);
        check("full_odat", {24'b0, odat}, 32'h10);
        tick();
        tick();
        check("stall_odat", {24'b0, odat}, 32'h10);
        ivld = 1'b0;
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_occ", {30'b0, occ}, 32'(3 - i));
            tick();
        end

        // Bubble collapse
        ordy = 1'b0;
        ivld = 1'b1; idat = 8'h20; tick();
        ivld = 1'b0;               tick();
        ivld = 1'b1; idat = 8'h21; tick();
        ivld = 1'b0;               tick();
        #1;
        check("bub_occ", {30'b0, occ}, 2);
        check("bub_irdy", {31'b0, irdy}, 1);
        check("bub_ovld", {31'b0, ovld}, 1);
        check("bub_odat", {24'b0, odat}, 32'h20);
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("bub_drained", {30'b0, occ}, 0);

        // Simultaneous in/out while full
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ivld = 1'b1;
            idat = 8'(8'h40 + i);
            tick();
        end
        ordy = 1'b1;
        ivld = 1'b1;
        idat = 8'h30;
        #1;
        check("simul_irdy", {31'b0, irdy}, 1);
        tick();
        check("simul_occ", {30'b0, occ}, 3);
        ivld = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Flush with occ=2 and a beat offered in the flush cycle
        ordy = 1'b0;
        ivld = 1'b1; idat = 8'h50; tick();
        ivld = 1'b1; idat = 8'h51; tick();
        check("pre_flush_occ", {30'b0, occ}, 2);
        flush = 1'b1;
        ivld  = 1'b1;
        idat  = 8'h5F;
        #1;
        check("flush_irdy", {31'b0, irdy}, 0);
        tick();
        flush = 1'b0;
        ivld  = 1'b0;
        check("flush_occ", {30'b0, occ}, 0);
        check("flush_ovld", {31'b0, ovld}, 0);
        ordy = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Reset while the output is stalled with a valid beat
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ivld = 1'b1;
            idat = 8'(8'h60 + i);
            tick();
        end
        ivld = 1'b0;
        check("prerst_ovld", {31'b0, ovld}, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_ovld", {31'b0, ovld}, 0);
        check("midrst_odat", {24'b0, odat}, {24'b0, RST_VAL});
        check("midrst_occ", {30'b0, occ}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/s_pl_pipe.md
Name: s_pl_pipe

Overview:
- Parametrised elastic pipeline register: DEPTH stages of SIZE-bit data, each stage with a valid bit.
- Uses a valid/ready handshake on both sides, so bubbles collapse and back-pressure stalls only the full stages.
- Adds a synchronous flush and an occupancy count.
- Drops into datapaths in place of fixed single-stage pipeline flops wherever retiming needs more than one stage and the consumer can stall.

Parameters:
- SIZE, 8, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- CNT_W, 2, width of occ; must satisfy 2^CNT_W > DEPTH.
- RST_VAL, {SIZE{1'b0}}, reset value of every stage data register.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- flush  input  1  synchronous clear of all stage valids.
- ivld  input  1  upstream data valid.
- irdy  output  1  pipeline can accept a beat this cycle.
- idat  input  SIZE  upstream data.
- ovld  output  1  output stage holds a valid beat.
- ordy  input  1  downstream accepts the beat this cycle.
- odat  output  SIZE  output stage data.
- occ  output  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- Stages are indexed 0 (input side) to DEPTH-1 (output side).
  - vld[k] and dat[k] are the per-stage valid and data registers.
  - ovld = vld[DEPTH-1] and odat = dat[DEPTH-1]; both are direct register outputs.
- Ready chain (combinational):
  - rdy[DEPTH] = ordy.
  - rdy[k] = !vld[k] | rdy[k+1].
  - irdy = rdy[0] & !flush.
  - The ordy-to-irdy path spans DEPTH gates; this is accepted.
- Transfers:
  - An input beat transfers when ivld & irdy.
  - An output beat transfers when ovld & ordy.
- Per stage k, on a clock edge with rst_n=1 and flush=0:
  - src_v = (k==0) ? ivld : vld[k-1]; src_d = (k==0) ? idat : dat[k-1].
  - If rdy[k]: vld[k] <= src_v, and dat[k] <= src_d only when src_v=1. An empty source leaves dat[k] unchanged.
  - If !rdy[k]: vld[k] and dat[k] hold.
- Latency: with ordy held 1, a beat accepted on cycle n is ovld on cycle n+DEPTH.
  - Throughput is 1 beat/cycle.
  - A bubble in any stage is absorbed when downstream stalls, so full occupancy reaches DEPTH.
- Data stability: while ovld=1 and ordy=0, odat and ovld hold unchanged until the handshake completes.
- occ is registered: the count of set vld bits after each edge.
  - It is updated together with vld, never by separate arithmetic that could drift.
- Flush:
  - On an edge with flush=1 and rst_n=1, all vld <= 0 and occ <= 0; dat registers hold.
  - irdy=0 during flush, so no input beat is accepted.
  - An output handshake (ovld & ordy) in the flush cycle still counts as a completed transfer; the beat is not replayed.
- Reset: on an edge with rst_n=0, all vld <= 0, all dat <= RST_VAL, occ <= 0.
  - Reset has priority over flush and over any handshake, including reset asserted mid-transfer.
  - After reset: ovld=0, odat=RST_VAL, occ=0, irdy = !flush.
- Full: when occ=DEPTH and ordy=0, irdy=0.
  - When occ=DEPTH and ordy=1, irdy=1 and simultaneous in/out leaves occ=DEPTH.
- Empty: irdy=1 (absent flush), regardless of ordy.
- DEPTH=1 is legal and degenerates to a single-stage register slice with combinational ready: irdy = !vld | ordy.
- No combinational path from idat or ivld to any output.

Test Plan:
- Reset/idle: DEPTH=3, SIZE=8, RST_VAL=8'hA5; hold rst_n=0 for 2 cycles, then release with ivld=0 -> ovld=0, odat=8'hA5, occ=0, irdy=1.
- Streaming latency: DEPTH=3, ordy=1; feed 8'h01..8'h08 back-to-back starting cycle 0 -> 8'h01 appears with ovld on cycle 3, then one beat per cycle in order, no drops or duplicates.
- Back-pressure fill: ordy=0; push 8'h10, 8'h11, 8'h12 -> occ reaches 3, irdy=0, odat=8'h10 stable. Then raise ordy -> 8'h10, 8'h11, 8'h12 drain in order and occ steps 3,2,1,0.
- Bubble collapse: ordy=0; push 8'h20, idle 1 cycle, push 8'h21 -> both beats reach stages 2 and 1 with occ=2 and irdy=1.
- Simultaneous in/out at full: occ=3, ordy=1, ivld=1 with 8'h30 -> occ stays 3, output sequence continues, and 8'h30 emerges 3 transfers later.
- Flush and reset mid-operation:
  - flush for 1 cycle with occ=2 and ivld=1 -> occ=0, ovld=0 next cycle, irdy=0 during flush, and the flushed-cycle input is never output.
  - rst_n=0 while ovld=1 and ordy=0 -> next cycle ovld=0 and odat=RST_VAL.
